// File: rtl/rgb_hue_sequencer_if.sv
// Control and colour bus between the board switches, the hue sequencer and the
// downstream WS2812 driver.
interface rgb_hue_sequencer_if;
  logic        run;
  logic        dir;
  logic [1:0]  brightness;
  logic [23:0] rgb_color;
  logic [2:0]  segment;
  logic        step_tick;

  modport master (
    output run, dir, brightness,
    input  rgb_color, segment, step_tick
  );

  modport slave (
    input  run, dir, brightness,
    output rgb_color, segment, step_tick
  );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// Six-segment hue wheel generator with run/pause, direction and 4-level
// brightness, feeding a 24-bit RGB colour to the WS2812 driver.
module rgb_hue_sequencer #(
  parameter int unsigned STEP_CYCLES = 200000
) (
  input logic               clk,
  input logic               reset_n,
  rgb_hue_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STEP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  // Two-flop synchronisers for the switch inputs.
  logic [1:0] run_sync;
  logic [1:0] dir_sync;
  logic [1:0] bri_meta;
  logic [1:0] bri_s;
  logic       run_s;
  logic       dir_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_sync <= '0;
      dir_sync <= '0;
      bri_meta <= '0;
      bri_s    <= '0;
    end else begin
      run_sync <= {run_sync[0], bus.run};
      dir_sync <= {dir_sync[0], bus.dir};
      bri_meta <= bus.brightness;
      bri_s    <= bri_meta;
    end
  end

  assign run_s = run_sync[1];
  assign dir_s = dir_sync[1];

  // Prescaler holds its count while paused so a resume finishes the same step.
  logic [CNT_W-1:0] presc_cnt;
  logic             tick;

  assign tick = run_s && (presc_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (run_s) begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
    end
  end

  // Wheel position: segment 0..5 and level 0..255 within the segment.
  logic [2:0] seg_q, seg_d;
  logic [7:0] level_q, level_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q   <= '0;
      level_q <= '0;
    end else begin
      seg_q   <= seg_d;
      level_q <= level_d;
    end
  end

  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would otherwise infer a latch.
  always_comb begin
    seg_d   = seg_q;
    level_d = level_q;
    if (tick) begin
      if (seg_q > 3'd5) begin
        seg_d   = 3'd0;
        level_d = 8'd0;
      end else if (!dir_s) begin
        if (level_q != 8'hFF) begin
          level_d = level_q + 8'd1;
        end else begin
          level_d = 8'd0;
          seg_d   = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
        end
      end else begin
        if (level_q != 8'h00) begin
          level_d = level_q - 8'd1;
        end else begin
          level_d = 8'hFF;
          seg_d   = (seg_q == 3'd0) ? 3'd5 : seg_q - 3'd1;
        end
      end
    end
  end

  // Colour map; boundaries deliberately repeat a colour (1536-step wheel).
  logic [7:0] red, green, blue;
  logic [7:0] level_inv;

  assign level_inv = ~level_q;

  always_comb begin
    red   = 8'h00;
    green = 8'h00;
    blue  = 8'h00;
    case (seg_q)
      3'd0: begin red = 8'hFF;     green = level_q;   blue = 8'h00;     end
      3'd1: begin red = level_inv; green = 8'hFF;     blue = 8'h00;     end
      3'd2: begin red = 8'h00;     green = 8'hFF;     blue = level_q;   end
      3'd3: begin red = 8'h00;     green = level_inv; blue = 8'hFF;     end
      3'd4: begin red = level_q;   green = 8'h00;     blue = 8'hFF;     end
      3'd5: begin red = 8'hFF;     green = 8'h00;     blue = level_inv; end
      default: begin red = 8'h00;  green = 8'h00;     blue = 8'h00;     end
    endcase
  end

  // Output stage: step_tick is delayed one extra cycle so it lines up with the
  // registered colour of the new position.
  logic        moved_q;
  logic [23:0] rgb_q;
  logic        step_tick_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      moved_q     <= 1'b0;
      rgb_q       <= '0;
      step_tick_q <= 1'b0;
    end else begin
      moved_q     <= tick;
      rgb_q       <= {red >> bri_s, green >> bri_s, blue >> bri_s};
      step_tick_q <= moved_q;
    end
  end

  assign bus.rgb_color = rgb_q;
  assign bus.segment   = seg_q;
  assign bus.step_tick = step_tick_q;

endmodule

// File: doc/rgb_hue_sequencer.md
Name: rgb_hue_sequencer

Overview:
Generates the 24-bit RGB colour consumed by the WS2812 single-LED driver, sweeping a six-segment hue wheel at a programmable rate.
Supports run/pause, direction and a 4-level brightness scale.
Sits directly upstream of the driver; its rgb_color output ties straight to the driver's rgb_color input in the same 50 MHz domain.
All control inputs come from board switches and are asynchronous to clk.

Parameters:
STEP_CYCLES, 200000, clk cycles per hue step (4 ms at 50 MHz, full wheel of 1536 steps about 6.1 s); legal range 1 to 2^24-1.

Ports:
clk  input  1  50 MHz clock
reset_n  input  1  asynchronous active-low reset
run  input  1  async level; 1 = advance hue, 0 = freeze
dir  input  1  async level; 0 = forward (R->Y->G->C->B->M), 1 = reverse
brightness  input  2  async level; each channel right-shifted by this amount (0 = full)
rgb_color  output  24  [23:16]=R, [15:8]=G, [7:0]=B, registered
segment  output  3  current wheel segment 0..5, registered
step_tick  output  1  one-cycle pulse on each position change, registered

Behaviour:
- Synchronisers: run, dir and brightness each pass through a 2-flop synchroniser, reset to 0. All logic uses only the synchronised copies (run_s, dir_s, bri_s).
- Prescaler: counter width $clog2(STEP_CYCLES+1).
  - Increments while run_s=1; holds its value while run_s=0 (not cleared).
  - At STEP_CYCLES-1 it wraps to 0 and asserts the internal tick for that cycle.
  - STEP_CYCLES=1 gives a tick on every cycle with run_s=1.
- Position state: segment (3 b, 0..5) and level (8 b). Updated only on tick.
  - Forward: level<255 -> level+1; level==255 -> level=0 and segment=(segment==5)?0:segment+1.
  - Reverse: level>0 -> level-1; level==0 -> level=255 and segment=(segment==0)?5:segment-1.
  - dir_s is sampled on the tick cycle itself; a direction change mid-segment reverses from the current level with no jump.
  - Segment values 6 and 7 are unreachable; if ever present, the next tick forces segment=0, level=0.
- Colour map (L=level, ~L=255-L), as (R,G,B):
  - seg0 (255,L,0)
  - seg1 (~L,255,0)
  - seg2 (0,255,L)
  - seg3 (0,~L,255)
  - seg4 (L,0,255)
  - seg5 (255,0,~L)
  - Segment boundaries repeat one colour, e.g. seg0 L=255 and seg1 L=0 are both (255,255,0). This is intentional; the wheel has 1536 steps.
- Brightness: each 8-bit channel is logically shifted right by bri_s (0..3); no rounding.
- Output register:
  - rgb_color is recomputed every cycle from the current segment, level and bri_s, and registered.
  - Latency is 1 cycle from a position or brightness change to rgb_color.
  - step_tick is asserted in the same cycle rgb_color shows the new position.
  - segment output mirrors the segment register.
- Reset values (async assert):
  - rgb_color=0, segment=0, step_tick=0.
  - level=0, prescaler=0, synchronisers=0.
- Reset release: the first rising edge loads rgb_color=24'hFF0000 (brightness 0, since the synchronisers are 0). No tick occurs before run_s=1.
- Reset mid-operation: all state returns to reset values immediately; no partial colour is held.
- Run latency: run rising -> run_s after 2 edges -> first tick STEP_CYCLES cycles later -> rgb_color updated 1 cycle after that.
- Pause: run_s=0 freezes the prescaler, position, step_tick=0 and rgb_color, except that brightness changes still propagate (3 cycles from the input pin).

Test Plan:
1. Reset, STEP_CYCLES=4, run=0, brightness=0, hold 20 cycles -> rgb_color=24'hFF0000 from the first edge after release; step_tick never high.
2. run=1, dir=0 -> first step_tick 2+4+1 cycles after run rises, then every 4 cycles; rgb_color goes FF0100, FF0200, ...; after 256 ticks rgb_color=FFFF00 with segment=1; after 1536 ticks it returns to FF0000 with segment=0.
3. Reverse wrap: from reset, run=1, dir=1 -> first tick gives segment=5, level=255, rgb_color=24'hFF0000 (seg5 with ~255=0); next tick gives 24'hFF0001.
4. Brightness: park at seg2 L=128 (00FF80), brightness=2 -> rgb_color=003F20 within 3 cycles; brightness=3 -> 001F10.
5. Pause/resume: run 1->0 mid-count at prescaler=2 -> no further ticks and rgb_color frozen; run->1 -> next tick occurs after exactly 2 more cycles (plus 2 sync cycles), confirming the prescaler held rather than cleared.
6. Assert reset_n low mid-segment (e.g. seg3) for 1 cycle -> outputs 0 immediately (asynchronously); after release rgb_color=FF0000 and segment=0.
